// File: rtl/ex_operand_stage_pkg.sv
// ---------------------------------------------------------------------------
// ex_operand_stage_pkg
// Shared constants for the ID/EX operand stage: default datapath and
// register-address widths, the hardwired-zero register index and the ALU
// operation encodings understood by the downstream ALU.
// ---------------------------------------------------------------------------
package ex_operand_stage_pkg;

  localparam int DEF_DW   = 32;
  localparam int DEF_AW   = 5;

  // Register 0 always reads as zero, so it is never a forwarding target.
  localparam int REG_ZERO = 0;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SRL = 3'd4,
    ALU_SRA = 3'd5
  } alu_op_e;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// ---------------------------------------------------------------------------
// ex_operand_stage_fwd_mux
// Selects the freshest value for one latched source operand.
// Ports:
//   addr     - latched source register index
//   value    - latched register-file value for that index
//   mem_*    - write enable / destination / data of the MEM-stage producer
//   wb_*     - write enable / destination / data of the WB-stage producer
//   fwd_val  - forwarded operand value
// ---------------------------------------------------------------------------
module ex_operand_stage_fwd_mux
  import ex_operand_stage_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] value,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] fwd_val
);

  logic not_zero;

  // Register 0 is never overridden; the latched value is already 0.
  assign not_zero = (addr != AW'(REG_ZERO));

  // MEM holds the younger producer, so it takes priority over WB.
  always_comb begin
    fwd_val = value;
    if (mem_we && (mem_addr == addr) && not_zero) begin
      fwd_val = mem_data;
    end else if (wb_we && (wb_addr == addr) && not_zero) begin
      fwd_val = wb_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ---------------------------------------------------------------------------
// ex_operand_stage
// ID/EX pipeline register feeding the ALU. Latches decoded operands and
// control, forwards MEM/WB results onto rs/rt, and picks immediate or rt
// for operand B. Supports hazard-unit stall (hold) and flush (bubble).
// Ports:
//   clk, reset           - clock, asynchronous active-low reset
//   id_*                 - decoded instruction from ID
//   stall, flush         - hazard-unit controls (flush wins)
//   mem_*, wb_*          - forwarding sources from MEM and WB
//   alu_A, alu_B, alu_op - ALU inputs
//   ex_valid, ex_rd_addr, ex_regwrite - control passed down the pipe
// ---------------------------------------------------------------------------
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_val,
  input  logic [DW-1:0] id_rt_val,
  input  logic [AW-1:0] id_rs_addr,
  input  logic [AW-1:0] id_rt_addr,
  input  logic [DW-1:0] id_imm32,
  input  logic          id_use_imm,
  input  logic [2:0]    id_aluop,
  input  logic [AW-1:0] id_rd_addr,
  input  logic          id_regwrite,
  input  logic          stall,
  input  logic          flush,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] alu_A,
  output logic [DW-1:0] alu_B,
  output logic [2:0]    alu_op,
  output logic          ex_valid,
  output logic [AW-1:0] ex_rd_addr,
  output logic          ex_regwrite
);

  logic          valid;
  logic [DW-1:0] rs_val;
  logic [DW-1:0] rt_val;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic [DW-1:0] imm32;
  logic          use_imm;
  logic [2:0]    aluop;
  logic [AW-1:0] rd_addr;
  logic          regwrite;

  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;

  ex_operand_stage_fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rs (
    .addr     (rs_addr),
    .value    (rs_val),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .wb_we    (wb_we),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .fwd_val  (fwd_rs)
  );

  ex_operand_stage_fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rt (
    .addr     (rt_addr),
    .value    (rt_val),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .wb_we    (wb_we),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .fwd_val  (fwd_rt)
  );

  // Flush beats stall beats load. While stalled, the operand values are
  // rewritten with their forwarded versions so a producer that retires
  // during the stall is captured before it leaves WB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid    <= 1'b0;
      rs_val   <= '0;
      rt_val   <= '0;
      rs_addr  <= '0;
      rt_addr  <= '0;
      imm32    <= '0;
      use_imm  <= 1'b0;
      aluop    <= ALU_ADD;
      rd_addr  <= '0;
      regwrite <= 1'b0;
    end else if (flush) begin
      valid    <= 1'b0;
      rs_val   <= '0;
      rt_val   <= '0;
      rs_addr  <= '0;
      rt_addr  <= '0;
      imm32    <= '0;
      use_imm  <= 1'b0;
      aluop    <= ALU_ADD;
      rd_addr  <= '0;
      regwrite <= 1'b0;
    end else if (stall) begin
      rs_val   <= fwd_rs;
      rt_val   <= fwd_rt;
    end else begin
      valid    <= id_valid;
      rs_val   <= id_rs_val;
      rt_val   <= id_rt_val;
      rs_addr  <= id_rs_addr;
      rt_addr  <= id_rt_addr;
      imm32    <= id_imm32;
      use_imm  <= id_use_imm;
      aluop    <= id_aluop;
      rd_addr  <= id_rd_addr;
      regwrite <= id_regwrite & id_valid;
    end
  end

  assign alu_A       = fwd_rs;
  assign alu_B       = use_imm ? imm32 : fwd_rt;
  assign alu_op      = aluop;
  assign ex_valid    = valid;
  assign ex_rd_addr  = rd_addr;
  assign ex_regwrite = regwrite & valid;

endmodule

// File: tb/tb_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_operand_stage
// Directed self-checking bench for ex_operand_stage.
// ---------------------------------------------------------------------------
module tb_ex_operand_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          reset;
  logic          id_valid;
  logic [DW-1:0] id_rs_val;
  logic [DW-1:0] id_rt_val;
  logic [AW-1:0] id_rs_addr;
  logic [AW-1:0] id_rt_addr;
  logic [DW-1:0] id_imm32;
  logic          id_use_imm;
  logic [2:0]    id_aluop;
  logic [AW-1:0] id_rd_addr;
  logic          id_regwrite;
  logic          stall;
  logic          flush;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [DW-1:0] alu_A;
  logic [DW-1:0] alu_B;
  logic [2:0]    alu_op;
  logic          ex_valid;
  logic [AW-1:0] ex_rd_addr;
  logic          ex_regwrite;

  int tests_run;
  int tests_failed;

  ex_operand_stage #(.DW(DW), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs_val   (id_rs_val),
    .id_rt_val   (id_rt_val),
    .id_rs_addr  (id_rs_addr),
    .id_rt_addr  (id_rt_addr),
    .id_imm32    (id_imm32),
    .id_use_imm  (id_use_imm),
    .id_aluop    (id_aluop),
    .id_rd_addr  (id_rd_addr),
    .id_regwrite (id_regwrite),
    .stall       (stall),
    .flush       (flush),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .alu_A       (alu_A),
    .alu_B       (alu_B),
    .alu_op      (alu_op),
    .ex_valid    (ex_valid),
    .ex_rd_addr  (ex_rd_addr),
    .ex_regwrite (ex_regwrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Quiet all stimulus inputs except reset.
  task automatic set_idle();
    id_valid    = 1'b0;
    id_rs_val   = '0;
    id_rt_val   = '0;
    id_rs_addr  = '0;
    id_rt_addr  = '0;
    id_imm32    = '0;
    id_use_imm  = 1'b0;
    id_aluop    = 3'd0;
    id_rd_addr  = '0;
    id_regwrite = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_data    = '0;
    wb_we       = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
  endtask

  // Present one register-register instruction on the ID inputs.
  task automatic drive_id(input logic [DW-1:0] rs_v, input logic [DW-1:0] rt_v,
                          input logic [AW-1:0] rs_a, input logic [AW-1:0] rt_a,
                          input logic [2:0] op, input logic [AW-1:0] rd,
                          input logic rw);
    id_valid    = 1'b1;
    id_rs_val   = rs_v;
    id_rt_val   = rt_v;
    id_rs_addr  = rs_a;
    id_rt_addr  = rt_a;
    id_imm32    = '0;
    id_use_imm  = 1'b0;
    id_aluop    = op;
    id_rd_addr  = rd;
    id_regwrite = rw;
  endtask

  task automatic test_reset();
    drive_id(32'h11, 32'h22, 5'd1, 5'd2, 3'd2, 5'd3, 1'b1);
    tick();
    tests_run++;
    if (ex_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_preload_valid: got %b expected 1", ex_valid);
    end
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({alu_A, alu_B, alu_op, ex_valid, ex_rd_addr, ex_regwrite} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_async_clear: A=%h B=%h op=%0d v=%b rd=%0d rw=%b expected all 0",
               alu_A, alu_B, alu_op, ex_valid, ex_rd_addr, ex_regwrite);
    end
    set_idle();
    #1;
    reset = 1'b1;
    tick();
    tests_run++;
    if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_release_empty: v=%b rw=%b expected 0 0", ex_valid, ex_regwrite);
    end
  endtask

  task automatic test_basic_load();
    set_idle();
    drive_id(32'd5, 32'd3, 5'd10, 5'd11, 3'd1, 5'd8, 1'b1);
    tick();
    tests_run++;
    if (alu_A !== 32'd5 || alu_B !== 32'd3) begin
      tests_failed++;
      $display("[TB] FAIL basic_operands: A=%h B=%h expected 5 3", alu_A, alu_B);
    end
    tests_run++;
    if (alu_op !== 3'd1 || ex_rd_addr !== 5'd8 || ex_regwrite !== 1'b1 || ex_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL basic_control: op=%0d rd=%0d rw=%b v=%b expected 1 8 1 1",
               alu_op, ex_rd_addr, ex_regwrite, ex_valid);
    end
  endtask

  task automatic test_forward_priority();
    set_idle();
    drive_id(32'd1, 32'd1, 5'd4, 5'd4, 3'd0, 5'd9, 1'b1);
    tick();
    mem_we = 1'b1; mem_addr = 5'd4; mem_data = 32'hAA;
    wb_we  = 1'b1; wb_addr  = 5'd4; wb_data  = 32'hBB;
    #1;
    tests_run++;
    if (alu_A !== 32'hAA || alu_B !== 32'hAA) begin
      tests_failed++;
      $display("[TB] FAIL fwd_mem_priority: A=%h B=%h expected aa aa", alu_A, alu_B);
    end
    mem_we = 1'b0;
    #1;
    tests_run++;
    if (alu_A !== 32'hBB || alu_B !== 32'hBB) begin
      tests_failed++;
      $display("[TB] FAIL fwd_wb: A=%h B=%h expected bb bb", alu_A, alu_B);
    end
    wb_we = 1'b0;
    #1;
    tests_run++;
    if (alu_A !== 32'd1 || alu_B !== 32'd1) begin
      tests_failed++;
      $display("[TB] FAIL fwd_none: A=%h B=%h expected 1 1", alu_A, alu_B);
    end
    drive_id(32'd0, 32'd1, 5'd0, 5'd4, 3'd0, 5'd9, 1'b1);
    tick();
    mem_we = 1'b1; mem_addr = 5'd0; mem_data = 32'hAA;
    wb_we  = 1'b1; wb_addr  = 5'd0; wb_data  = 32'hBB;
    #1;
    tests_run++;
    if (alu_A !== 32'd0 || alu_B !== 32'd1) begin
      tests_failed++;
      $display("[TB] FAIL fwd_reg_zero: A=%h B=%h expected 0 1", alu_A, alu_B);
    end
  endtask

  task automatic test_refresh_on_hold();
    set_idle();
    drive_id(32'd1, 32'h22, 5'd7, 5'd2, 3'd3, 5'd9, 1'b1);
    tick();
    drive_id(32'h55, 32'h66, 5'd1, 5'd3, 3'd4, 5'd10, 1'b1);
    stall  = 1'b1;
    wb_we  = 1'b1; wb_addr  = 5'd7; wb_data  = 32'h1234;
    mem_we = 1'b1; mem_addr = 5'd2; mem_data = 32'hCAFE;
    #1;
    tests_run++;
    if (alu_A !== 32'h1234 || alu_B !== 32'hCAFE) begin
      tests_failed++;
      $display("[TB] FAIL hold_fwd_live: A=%h B=%h expected 1234 cafe", alu_A, alu_B);
    end
    tick();
    wb_we  = 1'b0;
    mem_we = 1'b0;
    #1;
    tests_run++;
    if (alu_A !== 32'h1234 || alu_B !== 32'hCAFE) begin
      tests_failed++;
      $display("[TB] FAIL hold_refresh_kept: A=%h B=%h expected 1234 cafe", alu_A, alu_B);
    end
    tests_run++;
    if (alu_op !== 3'd3 || ex_rd_addr !== 5'd9 || ex_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL hold_control: op=%0d rd=%0d v=%b expected 3 9 1", alu_op, ex_rd_addr, ex_valid);
    end
    tick();
    tests_run++;
    if (alu_A !== 32'h1234) begin
      tests_failed++;
      $display("[TB] FAIL hold_second_cycle: A=%h expected 1234", alu_A);
    end
    stall = 1'b0;
    tick();
    tests_run++;
    if (alu_A !== 32'h55 || alu_B !== 32'h66 || alu_op !== 3'd4 || ex_rd_addr !== 5'd10) begin
      tests_failed++;
      $display("[TB] FAIL hold_release_load: A=%h B=%h op=%0d rd=%0d expected 55 66 4 10",
               alu_A, alu_B, alu_op, ex_rd_addr);
    end
  endtask

  task automatic test_immediate_select();
    set_idle();
    drive_id(32'd0, 32'd2, 5'd0, 5'd6, 3'd0, 5'd1, 1'b1);
    id_use_imm = 1'b1;
    id_imm32   = 32'hFFFF_FFF0;
    tick();
    tests_run++;
    if (alu_B !== 32'hFFFF_FFF0) begin
      tests_failed++;
      $display("[TB] FAIL imm_plain: B=%h expected fffffff0", alu_B);
    end
    mem_we = 1'b1; mem_addr = 5'd6; mem_data = 32'd9;
    #1;
    tests_run++;
    if (alu_B !== 32'hFFFF_FFF0) begin
      tests_failed++;
      $display("[TB] FAIL imm_ignores_fwd: B=%h expected fffffff0", alu_B);
    end
  endtask

  task automatic test_flush_vs_stall();
    set_idle();
    drive_id(32'h77, 32'h66, 5'd3, 5'd4, 3'd2, 5'd5, 1'b1);
    tick();
    drive_id(32'h88, 32'h99, 5'd8, 5'd9, 3'd5, 5'd12, 1'b1);
    stall = 1'b1;
    flush = 1'b1;
    tick();
    tests_run++;
    if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || alu_A !== '0 || alu_B !== '0 || alu_op !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL flush_bubble: v=%b rw=%b A=%h B=%h op=%0d expected 0 0 0 0 0",
               ex_valid, ex_regwrite, alu_A, alu_B, alu_op);
    end
    stall = 1'b0;
    flush = 1'b0;
    tick();
    tests_run++;
    if (alu_A !== 32'h88 || alu_B !== 32'h99 || alu_op !== 3'd5 || ex_rd_addr !== 5'd12 ||
        ex_valid !== 1'b1 || ex_regwrite !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL flush_then_load: A=%h B=%h op=%0d rd=%0d v=%b rw=%b expected 88 99 5 12 1 1",
               alu_A, alu_B, alu_op, ex_rd_addr, ex_valid, ex_regwrite);
    end
  endtask

  task automatic test_back_to_back();
    set_idle();
    drive_id(32'h1, 32'h2, 5'd1, 5'd2, 3'd7, 5'd15, 1'b1);
    tick();
    tests_run++;
    if (alu_op !== 3'd7 || ex_rd_addr !== 5'd15) begin
      tests_failed++;
      $display("[TB] FAIL b2b_opcode_passthru: op=%0d rd=%0d expected 7 15", alu_op, ex_rd_addr);
    end
    drive_id(32'h3, 32'h4, 5'd5, 5'd6, 3'd1, 5'd16, 1'b1);
    id_valid = 1'b0;
    tick();
    tests_run++;
    if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_rd_addr !== 5'd16) begin
      tests_failed++;
      $display("[TB] FAIL b2b_invalid_no_write: v=%b rw=%b rd=%0d expected 0 0 16",
               ex_valid, ex_regwrite, ex_rd_addr);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    set_idle();
    reset = 1'b0;
    #1;
    tests_run++;
    if ({alu_A, alu_B, alu_op, ex_valid, ex_rd_addr, ex_regwrite} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL initial_reset: A=%h B=%h op=%0d v=%b rd=%0d rw=%b expected all 0",
               alu_A, alu_B, alu_op, ex_valid, ex_rd_addr, ex_regwrite);
    end
    tick();
    reset = 1'b1;
    tick();
    test_reset();
    test_basic_load();
    test_forward_priority();
    test_refresh_on_hold();
    test_immediate_select();
    test_flush_vs_stall();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
